rd_writeback: RTL and testbench
===============================

Name: rd_writeback

Overview:
- Return path of the operand datapath: takes the ALU result, its opcode and destination register address, and writes it back into the register file through a single write port.
- Buffers results in a small FIFO so the ALU is not stalled by a multi-cycle register-file write acknowledge.
- Filters out opcodes that carry no writeback and counts committed and dropped results.

Parameters:
- N, 16, data width of result and register-file write data.
- AW, 3, register address width.
- DEPTH, 2, FIFO entries; power of 2, minimum 2.
- CW, 8, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  result, opcode and rd_addr are valid.
- alu_ready  out  1  block can accept a result.
- opcode  in  4  opcode of the result.
- rd_addr  in  AW  destination register.
- result  in  N  ALU result.
- rf_we  out  1  write request to the register file.
- rf_waddr  out  AW  write address.
- rf_wdata  out  N  write data.
- rf_ack  in  1  register file accepted the write this cycle.
- busy  out  1  FIFO non-empty or write in flight.
- wb_cnt  out  CW  count of committed writes.
- drop_cnt  out  CW  count of results accepted but not written.
- fwd_raddr  in  AW  forwarding lookup address; present only with WB_FWD_EN.
- fwd_hit  out  1  forwarding match; present only with WB_FWD_EN.
- fwd_data  out  N  forwarding data; present only with WB_FWD_EN.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - FIFO empty, state IDLE.
  - rf_we=0; rf_waddr=0; rf_wdata=0.
  - wb_cnt=0; drop_cnt=0; busy=0.
  - alu_ready=0 during the reset cycle and 1 in the first cycle after reset.
- Accept:
  - A transfer occurs on the rising edge where alu_valid && alu_ready.
  - alu_ready = (count < DEPTH) && !rst. It is registered-state only, with no combinational path from rf_ack.
  - When full, no push occurs even if a pop happens in the same cycle.
- Opcode filter:
  - Opcodes 4'b0000–4'b0100 are writeback ops and are pushed as {rd_addr, result}.
  - Any other opcode is consumed (the handshake completes), not pushed, and drop_cnt increments.
- FSM, two states:
  - IDLE: rf_we=0. Next state is WRITE if the next count > 0.
  - WRITE: rf_we=1; rf_waddr/rf_wdata come from the FIFO head. On rf_ack the head is popped and wb_cnt increments. Stay in WRITE if the next count > 0, otherwise go to IDLE.
- Timing:
  - Latency: a result accepted on edge k is presented with rf_we=1 in the cycle after edge k.
  - Back-to-back writes keep rf_we high continuously; the head updates on the cycle after each ack.
- rf_ack handling: while rf_we=0, rf_ack is ignored (no pop, no count).
- Simultaneous push and pop: count is unchanged, and FIFO order is preserved.
- Counters: wb_cnt and drop_cnt wrap modulo 2^CW.
- busy = (count != 0).
- Reset mid-write: pending entries are discarded, and rf_we is 0 in the cycle after the reset edge.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - fwd_* ports exist.
  - fwd_hit=1 when any valid FIFO entry has address == fwd_raddr.
  - fwd_data is the youngest matching entry. This is combinational from FIFO state only.
- Undefined: fwd_* ports and the lookup logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants for the five ALU ops.
  - Function is_wb_op(opcode).
  - Typedef wb_entry_t {addr, data}.
- One sub-module, wb_fifo:
  - Parameterised synchronous FIFO of wb_entry_t.
  - push/pop/full/empty/count interface.
  - Exposes entry array and valid mask for forwarding.

Test Plan:
- Reset, then idle: alu_ready=1, rf_we=0, wb_cnt=0, drop_cnt=0, busy=0.
- Push opcode=0000, rd=3, result=16'h1234, with rf_ack=1 held high:
  - rf_we=1, waddr=3, wdata=16'h1234 one cycle after the accept.
  - wb_cnt=1 afterwards; rf_we=0 the following cycle.
- Push opcode=4'b0111 with rd=5: handshake completes, rf_we never asserts, drop_cnt=1.
- rf_ack held 0, push 3 valid results (rd 1, 2, 3):
  - alu_ready=0 after 2 accepts; the third push is held.
  - Release rf_ack: writes occur in order 1, 2, 3; wb_cnt=3.
- Continuous ALU stream with rf_ack=1: rf_we stays high, one write per cycle, no drops.
- Assert rst while the FIFO is full and in WRITE: rf_we=0 the next cycle, busy=0, counters=0. With WB_FWD_EN, also check push rd=4 then rd=4 again and fwd_raddr=4 → fwd_hit=1, data from the second push.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU opcodes, writeback entry type and FSM state type
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;

  localparam int WB_N  = 16;
  localparam int WB_AW = 3;

  // Default-width writeback entry; the top re-declares it at its own widths.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_N-1:0]  data;
  } wb_entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wb_state_t;

  // Only the five ALU ops produce a register-file write; anything above is dropped.
  function automatic logic is_wb_op(input logic [3:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback entries exposing its storage for forwarding
module wb_fifo
  import cpu_pkg::*;
#(
  parameter type T     = wb_entry_t,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output T [DEPTH-1:0]               entries,
  output logic [DEPTH-1:0]           valid,
  output logic [$clog2(DEPTH)-1:0]   head_ptr
);

  localparam int PW = $clog2(DEPTH);

  T [DEPTH-1:0]  mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;
  logic [PW-1:0] off;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head     = mem_q[rd_ptr_q];
  assign entries  = mem_q;
  assign head_ptr = rd_ptr_q;

  // Next-state for storage, pointers and occupancy; overflow/underflow requests are ignored.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry is valid when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr_q;
      valid[i] = ({1'b0, off} < count_q);
    end
  end

  // Pointers and occupancy are reset; storage contents need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rd_writeback.sv
// rtl/rd_writeback.sv - ALU result writeback to register file via FIFO; optional WB_FWD_EN forwarding lookup
module rd_writeback
  import cpu_pkg::*;
#(
  parameter int N     = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [3:0]    opcode,
  input  logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  result,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [N-1:0]  rf_wdata,
  input  logic          rf_ack,
  output logic          busy,
  output logic [CW-1:0] wb_cnt,
  output logic [CW-1:0] drop_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0] fwd_raddr,
  output logic          fwd_hit,
  output logic [N-1:0]  fwd_data
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } entry_t;

  wb_state_t         state_q, state_d;
  logic [CW-1:0]     wb_cnt_q, wb_cnt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CNTW-1:0]   count_nxt;

  entry_t            push_entry;
  entry_t            head;
  entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]  fifo_valid;
  logic [PW-1:0]     fifo_head_ptr;
  logic [CNTW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic              accept, wb_op, push, pop;

  assign alu_ready  = !fifo_full && !rst;
  assign accept     = alu_valid && alu_ready;
  assign wb_op      = is_wb_op(opcode);
  assign push       = accept && wb_op;
  assign rf_we      = (state_q == S_WRITE);
  assign pop        = rf_we && rf_ack;
  assign push_entry = '{addr: rd_addr, data: result};

  assign rf_waddr = rf_we ? head.addr : '0;
  assign rf_wdata = rf_we ? head.data : '0;
  assign busy     = !fifo_empty;
  assign wb_cnt   = wb_cnt_q;
  assign drop_cnt = drop_cnt_q;

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .entries   (fifo_entries),
    .valid     (fifo_valid),
    .head_ptr  (fifo_head_ptr)
  );

  // Next occupancy drives the IDLE/WRITE decision; counters step on commit and on drop.
  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNTW'(1);
      2'b01:   count_nxt = fifo_count - CNTW'(1);
      default: count_nxt = fifo_count;
    endcase
    state_d    = (count_nxt != '0) ? S_WRITE : S_IDLE;
    wb_cnt_d   = wb_cnt_q + (pop ? CW'(1) : CW'(0));
    drop_cnt_d = drop_cnt_q + ((accept && !wb_op) ? CW'(1) : CW'(0));
  end

  // Writeback FSM and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wb_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wb_cnt_q   <= wb_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = fifo_head_ptr + PW'(k);
      if (fifo_valid[fwd_idx] && (fifo_entries[fwd_idx].addr == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_entries[fwd_idx].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fifo_entries, fifo_valid, fifo_head_ptr};
`endif

endmodule

// File: tb/tb_rd_writeback.sv
// tb/tb_rd_writeback.sv - directed table-driven bench for rd_writeback (WB_FWD_EN checks when defined)
module tb_rd_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  opcode;
  logic [2:0]  rd_addr;
  logic [15:0] result;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ack;
  logic        busy;
  logic [7:0]  wb_cnt;
  logic [7:0]  drop_cnt;
`ifdef WB_FWD_EN
  logic [2:0]  fwd_raddr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rd_writeback #(.N(16), .AW(3), .DEPTH(2), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .opcode    (opcode),
    .rd_addr   (rd_addr),
    .result    (result),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_ack    (rf_ack),
    .busy      (busy),
    .wb_cnt    (wb_cnt),
    .drop_cnt  (drop_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] res;
    logic        ack;
    logic        e_ready;
    logic        e_we;
    logic [2:0]  e_waddr;
    logic [15:0] e_wdata;
    logic        e_busy;
    logic [7:0]  e_wb;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [15:0] res, input logic ack);
    alu_valid = v;
    opcode    = op;
    rd_addr   = rd;
    result    = res;
    rf_ack    = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ready, input logic we,
                         input logic [2:0] waddr, input logic [15:0] wdata,
                         input logic bsy, input logic [7:0] wbc, input logic [7:0] drc);
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(ready));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    if (we) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(waddr));
      chk({tag, ".rf_wdata"}, 32'(rf_wdata), 32'(wdata));
    end
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".wb_cnt"}, 32'(wb_cnt), 32'(wbc));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(drc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           v  op     rd  res       ack  rdy we waddr wdata     busy wb    drop
    vecs[0] = '{1'b1, 4'h0, 3'd3, 16'h1234, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'd0, 8'd0};
    vecs[1] = '{1'b0, 4'h0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd3, 16'h1234, 1'b1, 8'd0, 8'd0};
    vecs[2] = '{1'b1, 4'h7, 3'd5, 16'hBEEF, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'd1, 8'd0};
    vecs[3] = '{1'b0, 4'h0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'd1, 8'd1};
    vecs[4] = '{1'b0, 4'h0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'd1, 8'd1};
    vecs[5] = '{1'b1, 4'h4, 3'd6, 16'h4444, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'd1, 8'd1};
    vecs[6] = '{1'b1, 4'h5, 3'd7, 16'h5555, 1'b0, 1'b1, 1'b1, 3'd6, 16'h4444, 1'b1, 8'd1, 8'd1};
    vecs[7] = '{1'b0, 4'h0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd6, 16'h4444, 1'b1, 8'd1, 8'd2};
    vecs[8] = '{1'b0, 4'h0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'd2, 8'd2};

    rst = 1'b1;
    drive(1'b0, 4'h0, 3'd0, 16'h0000, 1'b0);
`ifdef WB_FWD_EN
    fwd_raddr = 3'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.alu_ready", 32'(alu_ready), 32'd0);
    chk("reset.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset.rf_wdata", 32'(rf_wdata), 32'd0);
    chk_out("reset", 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    #1;
    chk("post_reset.alu_ready", 32'(alu_ready), 32'd1);

    // Table: single write with ack, dropped opcode, ignored ack while idle, opcode 4/5 boundary.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].res, vecs[i].ack);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_we, vecs[i].e_waddr,
              vecs[i].e_wdata, vecs[i].e_busy, vecs[i].e_wb, vecs[i].e_drop);
      tick();
    end

    // Backpressure: FIFO fills after two accepts, third push held, then drained in order.
    drive(1'b1, 4'h0, 3'd1, 16'h0101, 1'b0);
    #1;
    chk("bp.ready0", 32'(alu_ready), 32'd1);
    tick();
    drive(1'b1, 4'h1, 3'd2, 16'h0202, 1'b0);
    #1;
    chk_out("bp.c1", 1'b1, 1'b1, 3'd1, 16'h0101, 1'b1, 8'd2, 8'd2);
    tick();
    drive(1'b1, 4'h2, 3'd3, 16'h0303, 1'b0);
    #1;
    chk_out("bp.full", 1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 8'd2, 8'd2);
    tick();
    chk_out("bp.hold", 1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 8'd2, 8'd2);
    tick();
    drive(1'b1, 4'h2, 3'd3, 16'h0303, 1'b1);
    #1;
    chk_out("bp.w1", 1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 8'd2, 8'd2);
    tick();
    chk_out("bp.w2", 1'b1, 1'b1, 3'd2, 16'h0202, 1'b1, 8'd3, 8'd2);
    tick();
    drive(1'b0, 4'h0, 3'd0, 16'h0000, 1'b1);
    #1;
    chk_out("bp.w3", 1'b1, 1'b1, 3'd3, 16'h0303, 1'b1, 8'd4, 8'd2);
    tick();
    chk_out("bp.done", 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'd5, 8'd2);

    // Streaming: one accept and one write per cycle, rf_we held high.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i % 5), 3'(i), 16'hA000 + 16'(i), 1'b1);
      #1;
      chk($sformatf("stream%0d.ready", i), 32'(alu_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("stream%0d.we", i), 32'(rf_we), 32'd1);
        chk($sformatf("stream%0d.waddr", i), 32'(rf_waddr), 32'(i - 1));
        chk($sformatf("stream%0d.wdata", i), 32'(rf_wdata), 32'h0000A000 + 32'(i - 1));
      end
      tick();
    end
    drive(1'b0, 4'h0, 3'd0, 16'h0000, 1'b1);
    #1;
    chk_out("stream.last", 1'b1, 1'b1, 3'd5, 16'hA005, 1'b1, 8'd10, 8'd2);
    tick();
    chk_out("stream.done", 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'd11, 8'd2);

    // Drop counter wraps modulo 256: 257 drops from 2 lands on 3.
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 4'hF, 3'd0, 16'h0000, 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 3'd0, 16'h0000, 1'b0);
    #1;
    chk_out("wrap", 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'd11, 8'd3);

    // Reset while full and writing.
    drive(1'b1, 4'h0, 3'd1, 16'h1111, 1'b0);
    tick();
    drive(1'b1, 4'h0, 3'd2, 16'h2222, 1'b0);
    tick();
    drive(1'b1, 4'h0, 3'd3, 16'h3333, 1'b0);
    #1;
    chk_out("rstmid.pre", 1'b0, 1'b1, 3'd1, 16'h1111, 1'b1, 8'd11, 8'd3);
    rst = 1'b1;
    #1;
    chk("rstmid.ready_in_reset", 32'(alu_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 3'd0, 16'h0000, 1'b1);
    #1;
    chk("rstmid.waddr", 32'(rf_waddr), 32'd0);
    chk("rstmid.wdata", 32'(rf_wdata), 32'd0);
    chk_out("rstmid.post", 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'd0, 8'd0);
    tick();
    chk_out("rstmid.post2", 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'd0, 8'd0);

`ifdef WB_FWD_EN
    // Forwarding returns the youngest matching entry.
    drive(1'b1, 4'h0, 3'd4, 16'h1111, 1'b0);
    tick();
    drive(1'b1, 4'h1, 3'd4, 16'h2222, 1'b0);
    tick();
    drive(1'b0, 4'h0, 3'd0, 16'h0000, 1'b0);
    fwd_raddr = 3'd4;
    #1;
    chk("fwd.hit", 32'(fwd_hit), 32'd1);
    chk("fwd.data", 32'(fwd_data), 32'h2222);
    fwd_raddr = 3'd5;
    #1;
    chk("fwd.miss", 32'(fwd_hit), 32'd0);
    fwd_raddr = 3'd4;
    rf_ack = 1'b1;
    tick();
    chk("fwd.after_pop.hit", 32'(fwd_hit), 32'd1);
    chk("fwd.after_pop.data", 32'(fwd_data), 32'h2222);
    tick();
    chk("fwd.empty.hit", 32'(fwd_hit), 32'd0);
    rf_ack = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
